// File: rtl/pcs_rx_sync.sv
// rtl/pcs_rx_sync.sv - 1000BASE-X PCS receive code-group synchronization controller
// Qualifies code groups (comma/valid/bad), runs the sync FSM, registers SUDI.
module pcs_rx_sync (
  input  logic        clk,
  input  logic        reset,
  input  logic        signal_detect,
  input  logic [9:0]  rx_code_group,
  output logic        sync_status,
  output logic [10:0] SUDI
);

  typedef enum logic [3:0] {
    LOSS_OF_SYNC     = 4'd0,
    COMMA_DETECT_1   = 4'd1,
    ACQUIRE_SYNC_1   = 4'd2,
    COMMA_DETECT_2   = 4'd3,
    ACQUIRE_SYNC_2   = 4'd4,
    COMMA_DETECT_3   = 4'd5,
    SYNC_ACQUIRED_1  = 4'd6,
    SYNC_ACQUIRED_2  = 4'd7,
    SYNC_ACQUIRED_2A = 4'd8,
    SYNC_ACQUIRED_3  = 4'd9,
    SYNC_ACQUIRED_3A = 4'd10,
    SYNC_ACQUIRED_4  = 4'd11,
    SYNC_ACQUIRED_4A = 4'd12
  } state_e;

  // Membership in the negative-running-disparity code-group table: the 6b
  // sub-block picks the 5b index, its disparity picks the legal 4b set.
  function automatic logic in_table(input logic [9:0] v);
    logic [4:0] x;
    logic       hit;
    logic       k28;
    logic       rdp;
    logic       ok;
    logic [3:0] f;
    x   = 5'd0;
    hit = 1'b1;
    k28 = 1'b0;
    f   = v[3:0];
    rdp = ($countones(v[9:4]) > 3);
    case (v[9:4])
      6'b100111: x = 5'd0;
      6'b011101: x = 5'd1;
      6'b101101: x = 5'd2;
      6'b110001: x = 5'd3;
      6'b110101: x = 5'd4;
      6'b101001: x = 5'd5;
      6'b011001: x = 5'd6;
      6'b111000: x = 5'd7;
      6'b111001: x = 5'd8;
      6'b100101: x = 5'd9;
      6'b010101: x = 5'd10;
      6'b110100: x = 5'd11;
      6'b001101: x = 5'd12;
      6'b101100: x = 5'd13;
      6'b011100: x = 5'd14;
      6'b010111: x = 5'd15;
      6'b011011: x = 5'd16;
      6'b100011: x = 5'd17;
      6'b010011: x = 5'd18;
      6'b110010: x = 5'd19;
      6'b001011: x = 5'd20;
      6'b101010: x = 5'd21;
      6'b011010: x = 5'd22;
      6'b111010: x = 5'd23;
      6'b110011: x = 5'd24;
      6'b100110: x = 5'd25;
      6'b010110: x = 5'd26;
      6'b110110: x = 5'd27;
      6'b001110: x = 5'd28;
      6'b101110: x = 5'd29;
      6'b011110: x = 5'd30;
      6'b101011: x = 5'd31;
      6'b001111: k28 = 1'b1;
      default:   hit = 1'b0;
    endcase
    if (k28) begin
      ok = f inside {4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    end else if (!hit) begin
      ok = 1'b0;
    end else if (rdp) begin
      ok = (f inside {4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001})
        || (f == 4'b1000 && (x inside {5'd23, 5'd27, 5'd29, 5'd30}));
    end else begin
      ok = (f inside {4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110})
        || (f == 4'b1110 && !(x inside {5'd17, 5'd18, 5'd20}))
        || (f == 4'b0111 && (x inside {5'd17, 5'd18, 5'd20}));
    end
    return ok;
  endfunction

  state_e      state_q, state_d;
  logic        rx_even_q, rx_even_d;
  logic [1:0]  good_cgs_q, good_cgs_d;
  logic [10:0] sudi_q;

  logic valid, comma, is_data, cgbad, cggood;

  assign valid   = in_table(rx_code_group) || in_table(~rx_code_group);
  assign comma   = (rx_code_group[9:3] == 7'b0011111) || (rx_code_group[9:3] == 7'b1100000);
  assign is_data = valid && !comma;
  assign cgbad   = !valid || (comma && rx_even_q);
  assign cggood  = !cgbad;

  always_comb begin
    state_d    = state_q;
    good_cgs_d = good_cgs_q;
    case (state_q)
      LOSS_OF_SYNC:   if (comma) state_d = COMMA_DETECT_1;
      COMMA_DETECT_1: state_d = is_data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1: begin
        if (cgbad) state_d = LOSS_OF_SYNC;
        else if (comma && !rx_even_q) state_d = COMMA_DETECT_2;
      end
      COMMA_DETECT_2: state_d = is_data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_2: begin
        if (cgbad) state_d = LOSS_OF_SYNC;
        else if (comma && !rx_even_q) state_d = COMMA_DETECT_3;
      end
      COMMA_DETECT_3:  state_d = is_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
      SYNC_ACQUIRED_1: if (cgbad) state_d = SYNC_ACQUIRED_2;
      SYNC_ACQUIRED_2: begin
        if (cggood) begin
          state_d    = SYNC_ACQUIRED_2A;
          good_cgs_d = 2'd1;
        end else state_d = SYNC_ACQUIRED_3;
      end
      SYNC_ACQUIRED_3: begin
        if (cggood) begin
          state_d    = SYNC_ACQUIRED_3A;
          good_cgs_d = 2'd1;
        end else state_d = SYNC_ACQUIRED_4;
      end
      SYNC_ACQUIRED_4: begin
        if (cggood) begin
          state_d    = SYNC_ACQUIRED_4A;
          good_cgs_d = 2'd1;
        end else state_d = LOSS_OF_SYNC;
      end
      SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
        if (cgbad) begin
          good_cgs_d = 2'd0;
          state_d = (state_q == SYNC_ACQUIRED_2A) ? SYNC_ACQUIRED_3 :
                    (state_q == SYNC_ACQUIRED_3A) ? SYNC_ACQUIRED_4 : LOSS_OF_SYNC;
        end else if (good_cgs_q == 2'd3) begin
          good_cgs_d = 2'd0;
          state_d = (state_q == SYNC_ACQUIRED_2A) ? SYNC_ACQUIRED_1 :
                    (state_q == SYNC_ACQUIRED_3A) ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_3;
        end else good_cgs_d = good_cgs_q + 2'd1;
      end
      default: state_d = LOSS_OF_SYNC;
    endcase
    if (!signal_detect) state_d = LOSS_OF_SYNC;
  end

  // Comma alignment forces the even slot; otherwise parity simply alternates.
  assign rx_even_d = (state_d inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3}) ? 1'b1 : !rx_even_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOSS_OF_SYNC;
      rx_even_q  <= 1'b0;
      good_cgs_q <= 2'd0;
      sudi_q     <= 11'd0;
    end else begin
      state_q    <= state_d;
      rx_even_q  <= rx_even_d;
      good_cgs_q <= good_cgs_d;
      sudi_q     <= {rx_code_group, rx_even_d};
    end
  end

  assign sync_status = state_q inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                                       SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4,
                                       SYNC_ACQUIRED_4A};
  assign SUDI = sudi_q;

endmodule

// File: tb/tb_pcs_rx_sync.sv
// tb/tb_pcs_rx_sync.sv - scoreboard bench for pcs_rx_sync
// Reference model tracks comma count and error level with plain integers.
module tb_pcs_rx_sync;

  localparam logic [9:0] K28_5 = 10'b0011111010;
  localparam logic [9:0] D16_2 = 10'b0110110101;

  localparam logic [5:0] C6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] N4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] P4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] K4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        signal_detect = 1'b0;
  logic [9:0]  rx_code_group = 10'd0;
  logic        sync_status;
  logic [10:0] SUDI;

  int checks = 0;
  int failures = 0;

  bit         vld [1024];
  logic [9:0] syms [$];
  logic [11:0] exp_q [$];

  int m_mode = 0;
  int m_k = 0;
  int m_lvl = 0;
  int m_run = 0;
  bit m_even = 1'b0;

  always #5 clk = ~clk;

  pcs_rx_sync dut (
    .clk           (clk),
    .reset         (reset),
    .signal_detect (signal_detect),
    .rx_code_group (rx_code_group),
    .sync_status   (sync_status),
    .SUDI          (SUDI)
  );

  function automatic logic [9:0] enc(bit k, int x, int y);
    logic [5:0] s;
    logic [3:0] f;
    s = (k && x == 28) ? 6'b001111 : C6[x];
    if (k) f = (x == 28) ? K4[y] : 4'b1000;
    else if ($countones(s) > 3) f = (y == 7 && (x == 11 || x == 13 || x == 14)) ? 4'b1000 : P4[y];
    else f = (y == 7 && (x == 17 || x == 18 || x == 20)) ? 4'b0111 : N4[y];
    return {s, f};
  endfunction

  function automatic void add_sym(logic [9:0] c);
    vld[c] = 1'b1;
    syms.push_back(c);
  endfunction

  function automatic bit is_valid(logic [9:0] c);
    logic [9:0] nc;
    nc = ~c;
    return vld[c] || vld[nc];
  endfunction

  // Behavioural model: mode 0 lost, 1 waiting for data after comma m_k,
  // 2 acquiring after m_k commas, 3 in sync with error level m_lvl (1..4).
  task automatic drive(bit r, bit sd, logic [9:0] cg);
    bit comma, good, enter_cd;
    @(negedge clk);
    reset = r;
    signal_detect = sd;
    rx_code_group = cg;
    comma = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
    good = is_valid(cg) && !(comma && m_even);
    enter_cd = 1'b0;
    if (r) begin
      m_mode = 0; m_k = 0; m_lvl = 0; m_run = 0; m_even = 1'b0;
      exp_q.push_back(12'd0);
    end else begin
      if (!sd) m_mode = 0;
      else begin
        case (m_mode)
          0: if (comma) begin m_mode = 1; m_k = 1; enter_cd = 1'b1; end
          1: begin
            if (is_valid(cg) && !comma) begin
              if (m_k == 3) begin m_mode = 3; m_lvl = 1; m_run = 0; end
              else m_mode = 2;
            end else m_mode = 0;
          end
          2: begin
            if (!good) m_mode = 0;
            else if (comma) begin m_k = m_k + 1; m_mode = 1; enter_cd = 1'b1; end
          end
          default: begin
            if (!good) begin
              m_lvl = m_lvl + 1;
              m_run = 0;
              if (m_lvl == 5) m_mode = 0;
            end else if (m_lvl > 1) begin
              m_run = m_run + 1;
              if (m_run == 4) begin m_lvl = m_lvl - 1; m_run = 0; end
            end
          end
        endcase
      end
      m_even = enter_cd ? 1'b1 : !m_even;
      exp_q.push_back({(m_mode == 3), cg, m_even});
    end
  endtask

  task automatic alt(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? K28_5 : D16_2);
  endtask

  task automatic rep(int n, bit sd, logic [9:0] cg);
    for (int i = 0; i < n; i++) drive(1'b0, sd, cg);
  endtask

  initial begin : monitor
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sync_status !== e[11]) begin
          failures++;
          $display("FAIL sync_status t=%0t got=%b exp=%b", $time, sync_status, e[11]);
        end
        checks++;
        if (SUDI !== e[10:0]) begin
          failures++;
          $display("FAIL SUDI t=%0t got=%b exp=%b", $time, SUDI, e[10:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [9:0] cg;
    bit ph;
    int sel;
    for (int b = 0; b < 256; b++) add_sym(enc(1'b0, b % 32, b / 32));
    for (int y = 0; y < 8; y++) add_sym(enc(1'b1, 28, y));
    add_sym(enc(1'b1, 23, 7));
    add_sym(enc(1'b1, 27, 7));
    add_sym(enc(1'b1, 29, 7));
    add_sym(enc(1'b1, 30, 7));

    rep(2, 1'b1, K28_5);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, K28_5);
    alt(10);
    rep(4, 1'b1, 10'd0);
    alt(8);
    rep(3, 1'b1, 10'd0);
    rep(4, 1'b1, D16_2);
    rep(8, 1'b1, D16_2);
    rep(3, 1'b1, K28_5);
    rep(6, 1'b1, D16_2);
    alt(8);
    drive(1'b0, 1'b0, D16_2);
    alt(4);
    rep(2, 1'b1, D16_2);
    alt(8);
    alt(8);
    drive(1'b0, 1'b1, 10'd0);
    drive(1'b0, 1'b1, D16_2);
    drive(1'b1, 1'b1, D16_2);
    drive(1'b0, 1'b1, K28_5);
    drive(1'b0, 1'b1, D16_2);
    alt(6);

    ph = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 60) cg = ph ? D16_2 : K28_5;
      else if (sel < 85) cg = syms[$urandom_range(0, syms.size() - 1)];
      else if (sel < 95) cg = 10'($urandom_range(0, 1023));
      else cg = 10'd0;
      ph = !ph;
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) != 0), cg);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcs_rx_sync.md
# pcs_rx_sync

1000BASE-X PCS receive code-group synchronization controller. Takes raw 10-bit code groups from the deserializer and qualifies them as comma, valid, or invalid. It runs the synchronization state machine and drives `sync_status` plus the 11-bit `SUDI` word into the PCS receive state machine. It therefore gates and sequences the receive block: that block leaves LINK_FAILED only while this block asserts `sync_status`.

## Interface
- No parameters.
- `clk`  in  1  receive code-group clock; one code group per cycle.
- `reset`  in  1  synchronous, active-high.
- `signal_detect`  in  1  PMD signal present; level input.
- `rx_code_group`  in  10  raw code group, bit 9 = a … bit 0 = j (abcdeifghj).
- `sync_status`  out  1  1 while the state is any SYNC_ACQUIRED_*.
- `SUDI`  out  11  registered `{rx_code_group, rx_even}`:
  - `SUDI[10:1]` = code group.
  - `SUDI[0]` = even flag.

## Operation
- **Comma:** `rx_code_group[9:3]` is `7'b0011111` or `7'b1100000`.
- **valid:** the code group is in the shared code-group table (tablas.v `*_10B` macros), in either disparity (the value or its bitwise complement).
- **Data code group (D):** a valid code group that is not a comma.
- **cgbad:** `!valid || (comma && rx_even==1)`. `rx_even` is the current register value, so a comma landing in an odd slot counts as bad.
- **cggood:** `!cgbad`.
- **`rx_even` register:**
  - Set to 1 on any transition into COMMA_DETECT_1, COMMA_DETECT_2 or COMMA_DETECT_3.
  - Otherwise inverts every cycle.
- **`good_cgs`:** 2-bit counter, used only in the *A states.
- **States:** 13, one-hot or encoded.
  - LOSS_OF_SYNC → COMMA_DETECT_1 on `signal_detect && comma`; else stay.
  - COMMA_DETECT_1 → ACQUIRE_SYNC_1 on D; else LOSS_OF_SYNC.
  - ACQUIRE_SYNC_1:
    - cgbad → LOSS_OF_SYNC.
    - `comma && rx_even==0` → COMMA_DETECT_2.
    - Else stay.
  - COMMA_DETECT_2 → ACQUIRE_SYNC_2 on D; else LOSS_OF_SYNC.
  - ACQUIRE_SYNC_2: same rules as ACQUIRE_SYNC_1, with the comma case going to COMMA_DETECT_3.
  - COMMA_DETECT_3 → SYNC_ACQUIRED_1 on D; else LOSS_OF_SYNC.
  - SYNC_ACQUIRED_1: cggood → stay; cgbad → SYNC_ACQUIRED_2.
  - SYNC_ACQUIRED_n (n = 2, 3, 4):
    - cggood → SYNC_ACQUIRED_nA with `good_cgs`=1.
    - cgbad → SYNC_ACQUIRED_(n+1); for n=4 this is LOSS_OF_SYNC.
  - SYNC_ACQUIRED_nA:
    - cgbad → SYNC_ACQUIRED_(n+1); for n=4 this is LOSS_OF_SYNC.
    - cggood with `good_cgs`==3 → SYNC_ACQUIRED_(n-1), with `good_cgs` cleared.
    - cggood otherwise → stay, `good_cgs`+1.
- **Override:** `signal_detect`==0 forces next state LOSS_OF_SYNC from any state. This takes priority over all other transitions.
- **Illegal encoding:** an illegal or unreachable state returns to LOSS_OF_SYNC on the next edge.

## Timing
- **Reset values:** state LOSS_OF_SYNC, `rx_even`=0, `good_cgs`=0, `SUDI`=11'b0, `sync_status`=0.
- **`SUDI` latency:** 1 cycle. On each edge, `SUDI` ← `{rx_code_group, rx_even_next}`, where `rx_even_next` is the value of `rx_even` written on that same edge.
- **`sync_status`:** decoded from the state register only, with no combinational path from inputs. It changes on the same edge that registers the code group causing the transition.
- **Reset mid-operation:** reset has priority. All registers take their reset values on the next edge, regardless of state or `signal_detect`.
- **Concurrent events:** when `signal_detect` falls in the same cycle as a cgbad, the result is LOSS_OF_SYNC.
- **`rx_even` during loss:** keeps toggling in LOSS_OF_SYNC. This keeps `SUDI[0]` alternating in every state except on comma re-alignment.

## Test plan
- **Acquire:**
  - Stimulus: after reset, `signal_detect`=1, alternate K28.5 `10'b0011111010` with D16.2 `10'b0110110101`.
  - Response: `sync_status` rises on the 6th sampled code group.
  - Every `SUDI` carrying K28.5 has `SUDI[0]`=1; every `SUDI` carrying D16.2 has `SUDI[0]`=0.
- **Lose sync:**
  - Stimulus: in SYNC_ACQUIRED_1, apply 4 consecutive `10'b0000000000`.
  - Response: `sync_status` stays 1 through the 3rd bad code group and goes to 0 on the edge sampling the 4th.
- **Recover without loss:**
  - Stimulus: in SYNC_ACQUIRED_1, apply 3 bad code groups, then 4 D16.2.
  - Response: state ends in SYNC_ACQUIRED_3 and `sync_status` stays 1 throughout.
  - Further goods: 8 more D16.2 return the state to SYNC_ACQUIRED_1.
- **Odd comma:**
  - Stimulus: in SYNC_ACQUIRED_1, apply K28.5 while `rx_even`=1.
  - Response: state goes to SYNC_ACQUIRED_2 (counted as bad) and `SUDI[0]` keeps alternating.
- **signal_detect drop:**
  - Stimulus: deassert `signal_detect` for 1 cycle while in sync.
  - Response: `sync_status`=0 on the next edge, and re-acquisition requires the full 3-comma sequence.
- **Mid-operation reset:**
  - Stimulus: pulse reset while in SYNC_ACQUIRED_2A.
  - Response: next cycle `SUDI`=0, `sync_status`=0, state LOSS_OF_SYNC.
  - Follow-up: a K28.5 input still reaches COMMA_DETECT_1.
